// File: rtl/conway_board_loader.sv
// Row-by-row board loader for the toroidal Life grid: collects ROWS rows into a
// shadow buffer and commits a well-framed board to the grid in one cycle.
module conway_board_loader #(
  parameter int ROWS = 16,
  parameter int COLS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   row_valid,
  output logic                   row_ready,
  input  logic [COLS-1:0]        row_data,
  input  logic                   row_last,
  output logic                   load,
  output logic [ROWS*COLS-1:0]   data,
  output logic                   frame_err,
  output logic [15:0]            frame_count
);

  localparam int IDX_W = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam int SHW   = (ROWS - 1) * COLS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_LOAD  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SHW-1:0]         shadow_q, shadow_d;
  logic [ROWS*COLS-1:0]   data_q, data_d;
  logic                   load_q, load_d;
  logic                   err_q, err_d;
  logic [15:0]            count_q, count_d;
  logic                   accept_s;

  // Ready is a pure state decode so upstream never sees a valid->ready path.
  assign row_ready = (state_q != S_LOAD);
  assign accept_s  = row_valid & row_ready;

  // Next-state, shadow capture and commit decisions.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    load_d   = 1'b0;
    err_d    = 1'b0;
    count_d  = count_q;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (accept_s) begin
          if (row_last) begin
            err_d = 1'b1;
          end else begin
            shadow_d[0 +: COLS] = row_data;
            idx_d               = IDX_W'(1);
            state_d             = S_FILL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (accept_s) begin
          if (idx_q == LAST_IDX) begin
            if (row_last) begin
              // Final row goes straight to the output; shadow holds rows 0..ROWS-2.
              data_d  = {row_data, shadow_q};
              load_d  = 1'b1;
              count_d = count_q + 16'd1;
              state_d = S_LOAD;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            if (row_last) begin
              err_d   = 1'b1;
              idx_d   = '0;
              state_d = S_IDLE;
            end else begin
              shadow_d[COLS*idx_q +: COLS] = row_data;
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_DRAIN: begin
        if (accept_s && row_last) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_LOAD: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      load_q   <= load_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign load        = load_q;
  assign data        = data_q;
  assign frame_err   = err_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_conway_board_loader.sv
// Directed bench for conway_board_loader: per-cycle vector table plus
// hand-written back-pressure, mid-frame reset and counter-wrap sequences.
module tb_conway_board_loader;

  logic         clk;
  logic         rst_n;
  logic         row_valid;
  logic         row_ready;
  logic [15:0]  row_data;
  logic         row_last;
  logic         load;
  logic [255:0] data;
  logic         frame_err;
  logic [15:0]  frame_count;

  int checks = 0;
  int errors = 0;

  conway_board_loader #(.ROWS(16), .COLS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_data    (row_data),
    .row_last    (row_last),
    .load        (load),
    .data        (data),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         valid;
    logic [15:0]  rdata;
    logic         last;
    logic         exp_ready;
    logic         exp_load;
    logic         exp_err;
    logic [15:0]  exp_cnt;
    logic [255:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [15:0] d, input logic l, input logic er,
                     input logic el, input logic ee, input logic [15:0] ec, input logic [255:0] ed);
    vec_t x;
    x.valid = v; x.rdata = d; x.last = l; x.exp_ready = er;
    x.exp_load = el; x.exp_err = ee; x.exp_cnt = ec; x.exp_data = ed;
    vecs.push_back(x);
  endtask

  task automatic step_row(input logic v, input logic [15:0] d, input logic l);
    @(negedge clk);
    row_valid = v; row_data = d; row_last = l;
    @(posedge clk);
    #1;
  endtask

  // Sends one good 16-row frame from IDLE and checks the commit cycle.
  task automatic send_frame(input logic [15:0] base, input logic [15:0] exp_cnt);
    logic [255:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) begin
      b[16*i +: 16] = base + 16'(i);
      step_row(1'b1, base + 16'(i), (i == 15));
      if (i < 15) chk("fill_no_load", 256'(load), 256'(1'b0));
    end
    chk("commit_load", 256'(load), 256'(1'b1));
    chk("commit_ready", 256'(row_ready), 256'(1'b0));
    chk("commit_err", 256'(frame_err), 256'(1'b0));
    chk("commit_data", data, b);
    chk("commit_count", 256'(frame_count), 256'(exp_cnt));
    step_row(1'b0, 16'h0000, 1'b0);
    chk("load_one_cycle", 256'(load), 256'(1'b0));
    chk("ready_after_load", 256'(row_ready), 256'(1'b1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] cur;
    logic [255:0] pend;
    logic [255:0] bd;
    logic [255:0] be;
    logic [15:0]  cnt;
    logic [15:0]  item;
    logic         rdy;
    int           p, cyc, l1, l2;

    rst_n = 1'b0; row_valid = 1'b0; row_data = 16'h0000; row_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data, 256'd0);
    chk("rst_load", 256'(load), 256'd0);
    chk("rst_err", 256'(frame_err), 256'd0);
    chk("rst_count", 256'(frame_count), 256'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_ready", 256'(row_ready), 256'(1'b1));

    // Vector table: good, short, long, single-row short, good again.
    cur = '0; pend = '0; cnt = 16'd0;
    for (int i = 0; i < 16; i++) begin
      pend[16*i +: 16] = 16'(i + 1);
      if (i == 15) begin cur = pend; cnt = 16'd1; end
      add(1'b1, 16'(i + 1), (i == 15), (i != 15), (i == 15), 1'b0, cnt, cur);
    end
    add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, cnt, cur);
    for (int i = 0; i < 4; i++)
      add(1'b1, 16'hA000 + 16'(i), (i == 3), 1'b1, 1'b0, (i == 3), cnt, cur);
    add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, cnt, cur);
    for (int i = 0; i < 20; i++)
      add(1'b1, 16'hB000 + 16'(i), (i == 19), 1'b1, 1'b0, (i == 19), cnt, cur);
    add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, cnt, cur);
    add(1'b1, 16'h7777, 1'b1, 1'b1, 1'b0, 1'b1, cnt, cur);
    add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, cnt, cur);
    for (int i = 0; i < 16; i++) begin
      pend[16*i +: 16] = 16'hC000 + 16'(i);
      if (i == 15) begin cur = pend; cnt = 16'd2; end
      add(1'b1, 16'hC000 + 16'(i), (i == 15), (i != 15), (i == 15), 1'b0, cnt, cur);
    end
    add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, cnt, cur);

    for (int k = 0; k < vecs.size(); k++) begin
      step_row(vecs[k].valid, vecs[k].rdata, vecs[k].last);
      chk("vec_ready", 256'(row_ready), 256'(vecs[k].exp_ready));
      chk("vec_load", 256'(load), 256'(vecs[k].exp_load));
      chk("vec_err", 256'(frame_err), 256'(vecs[k].exp_err));
      chk("vec_count", 256'(frame_count), 256'(vecs[k].exp_cnt));
      chk("vec_data", data, vecs[k].exp_data);
    end

    // Back-pressure: valid held high across two frames.
    bd = '0; be = '0;
    for (int i = 0; i < 16; i++) begin
      bd[16*i +: 16] = 16'hD000 + 16'(i);
      be[16*i +: 16] = 16'hE000 + 16'(i);
    end
    p = 0; cyc = 0; l1 = -1; l2 = -1;
    while (l2 < 0 && cyc < 60) begin
      @(negedge clk);
      item = ((p < 16) ? 16'hD000 : 16'hE000) + 16'(p % 16);
      row_valid = 1'b1; row_data = item; row_last = ((p % 16) == 15);
      rdy = row_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (rdy) p++;
      if (load) begin
        chk("bp_ready_in_load", 256'(row_ready), 256'(1'b0));
        if (l1 < 0) begin
          l1 = cyc;
          chk("bp_board1", data, bd);
          chk("bp_count1", 256'(frame_count), 256'(16'd3));
        end else begin
          l2 = cyc;
          chk("bp_board2", data, be);
          chk("bp_count2", 256'(frame_count), 256'(16'd4));
        end
      end
    end
    @(negedge clk) row_valid = 1'b0;
    chk("bp_first_commit", 256'(l1), 256'(16));
    chk("bp_spacing", 256'(l2 - l1), 256'(17));

    // Reset in the middle of a frame.
    for (int i = 0; i < 8; i++) step_row(1'b1, 16'h5500 + 16'(i), 1'b0);
    @(negedge clk);
    row_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst_data", data, 256'd0);
    chk("midrst_load", 256'(load), 256'd0);
    chk("midrst_err", 256'(frame_err), 256'd0);
    chk("midrst_count", 256'(frame_count), 256'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("midrst_ready", 256'(row_ready), 256'(1'b1));
    send_frame(16'h6600, 16'd1);

    // Counter wrap: preset the counter to its top value, then commit once.
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    #1 release dut.count_q;
    #1 chk("wrap_preset", 256'(frame_count), 256'(16'hFFFF));
    send_frame(16'h3300, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
